// File: rtl/pipe_hazard_if.sv
// Decode-side hazard bus between the pipeline datapath and the hazard controller.
// The master drives decode and redirect information, and the slave returns the enables and forwarding selects.
interface pipe_hazard_if;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned FWD_W  = 2;

    logic              i_id_valid;
    logic [REG_AW-1:0] i_id_rs1;
    logic [REG_AW-1:0] i_id_rs2;
    logic              i_id_use_rs1;
    logic              i_id_use_rs2;
    logic [REG_AW-1:0] i_id_rd;
    logic              i_id_regwrite;
    logic              i_id_memread;
    logic              i_id_halt;
    logic              i_ex_redirect;

    logic              o_pc_en;
    logic              o_ifid_en;
    logic              o_ifid_flush;
    logic              o_idex_bubble;
    logic [FWD_W-1:0]  o_fwd_a;
    logic [FWD_W-1:0]  o_fwd_b;
    logic              o_retire_halt;
    logic              o_halted;

    modport master (
        output i_id_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
               i_id_rd, i_id_regwrite, i_id_memread, i_id_halt, i_ex_redirect,
        input  o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble,
               o_fwd_a, o_fwd_b, o_retire_halt, o_halted
    );

    modport slave (
        input  i_id_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
               i_id_rd, i_id_regwrite, i_id_memread, i_id_halt, i_ex_redirect,
        output o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble,
               o_fwd_a, o_fwd_b, o_retire_halt, o_halted
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller.
// It tracks shadow EX/MEM/WB slots and generates stalls, operand forwarding, flushes and the EBREAK halt sequence.
module pipe_hazard_ctrl #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    pipe_hazard_if.slave  bus
);
    localparam int unsigned REG_AW = 5;
    localparam int unsigned FWD_W  = 2;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

    // EX needs memread for load-use detection; later slots only matter as producers or for halt
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic              halt;
    } ex_slot_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              halt;
    } late_slot_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HALTED  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    ex_slot_t          ex_q, ex_d;
    late_slot_t        mem_q, mem_d;
    late_slot_t        wb_q, wb_d;
    logic [FWD_W-1:0]  fwd_a_q, fwd_a_d;
    logic [FWD_W-1:0]  fwd_b_q, fwd_b_d;
    logic              halted_q, halted_d;

    logic              ex_rs1_c, ex_rs2_c;
    logic              mem_rs1_c, mem_rs2_c;
    logic              wb_rs1_c, wb_rs2_c;
    logic              load_use_c, any_raw_c, raw_stall_c;
    logic              run_c, id_adv_c, retire_halt_c;

    // x0 is hardwired, so it never produces a value worth waiting for or forwarding
    function automatic logic produces(input logic valid, input logic regwrite,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] rs);
        return valid & regwrite & (rd == rs) & (rs != REG_AW'(0));
    endfunction

    function automatic logic [FWD_W-1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
        if (ex_hit)       return FWD_MEM;
        else if (mem_hit) return FWD_WB;
        else              return FWD_RF;
    endfunction

    // Operand matches against every in-flight producer
    always_comb begin
        ex_rs1_c  = produces(ex_q.valid,  ex_q.regwrite,  ex_q.rd,  bus.i_id_rs1);
        ex_rs2_c  = produces(ex_q.valid,  ex_q.regwrite,  ex_q.rd,  bus.i_id_rs2);
        mem_rs1_c = produces(mem_q.valid, mem_q.regwrite, mem_q.rd, bus.i_id_rs1);
        mem_rs2_c = produces(mem_q.valid, mem_q.regwrite, mem_q.rd, bus.i_id_rs2);
        wb_rs1_c  = produces(wb_q.valid,  wb_q.regwrite,  wb_q.rd,  bus.i_id_rs1);
        wb_rs2_c  = produces(wb_q.valid,  wb_q.regwrite,  wb_q.rd,  bus.i_id_rs2);
    end

    // Stall, advance and the combinational enables
    always_comb begin
        load_use_c = bus.i_id_valid & ex_q.memread &
                     ((ex_rs1_c & bus.i_id_use_rs1) | (ex_rs2_c & bus.i_id_use_rs2));
        any_raw_c  = bus.i_id_valid &
                     ((bus.i_id_use_rs1 & (ex_rs1_c | mem_rs1_c | wb_rs1_c)) |
                      (bus.i_id_use_rs2 & (ex_rs2_c | mem_rs2_c | wb_rs2_c)));
        raw_stall_c = FWD_EN ? load_use_c : any_raw_c;

        run_c         = (state_q == ST_RUN);
        id_adv_c      = bus.i_id_valid & run_c & ~raw_stall_c & ~bus.i_ex_redirect;
        retire_halt_c = wb_q.valid & wb_q.halt;
    end

    // A taken redirect kills the stalled instruction anyway, so the fetch side keeps moving
    assign bus.o_pc_en       = run_c & (~raw_stall_c | bus.i_ex_redirect);
    assign bus.o_ifid_en     = run_c & (~raw_stall_c | bus.i_ex_redirect);
    assign bus.o_ifid_flush  = run_c & bus.i_ex_redirect;
    assign bus.o_idex_bubble = ~id_adv_c;
    assign bus.o_retire_halt = retire_halt_c;
    assign bus.o_fwd_a       = fwd_a_q;
    assign bus.o_fwd_b       = fwd_b_q;
    assign bus.o_halted      = halted_q;

    // Halt sequencing: once EBREAK issues, everything older is already ahead of it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (id_adv_c && bus.i_id_halt) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (retire_halt_c) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        halted_d = (state_d == ST_HALTED);
    end

    // Shadow slot shift and forwarding-select capture
    always_comb begin
        ex_d  = '0;
        mem_d = '0;
        wb_d  = '0;
        if (id_adv_c) begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = bus.i_id_rd;
            ex_d.regwrite = bus.i_id_regwrite;
            ex_d.memread  = bus.i_id_memread;
            ex_d.halt     = bus.i_id_halt;
        end
        mem_d.valid    = ex_q.valid;
        mem_d.rd       = ex_q.rd;
        mem_d.regwrite = ex_q.regwrite;
        mem_d.halt     = ex_q.halt;
        wb_d           = mem_q;

        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (id_adv_c && FWD_EN) begin
            fwd_a_d = fwd_sel(ex_rs1_c, mem_rs1_c);
            fwd_b_d = fwd_sel(ex_rs2_c, mem_rs2_c);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_RUN;
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            fwd_a_q  <= FWD_RF;
            fwd_b_q  <= FWD_RF;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
            halted_q <= halted_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl.
// It drives a forwarding and a stall-only instance in lockstep and checks each cycle against expected outputs.
module tb_pipe_hazard_ctrl;

    typedef struct {
        logic       valid;
        logic [4:0] rs1;
        logic       use1;
        logic [4:0] rs2;
        logic       use2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       halt;
        logic       redir;
        logic       pc;
        logic       fl;
        logic       bub;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       ret;
        logic       hlt;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       id_valid, use1, use2, rw, mr, halt, redir;
    logic [4:0] rs1, rs2, rd;

    int   checks;
    int   failures;
    vec_t exp_q[$];
    vec_t tbl[22];

    pipe_hazard_if bus_f();
    pipe_hazard_if bus_n();

    assign bus_f.i_id_valid    = id_valid;
    assign bus_f.i_id_rs1      = rs1;
    assign bus_f.i_id_rs2      = rs2;
    assign bus_f.i_id_use_rs1  = use1;
    assign bus_f.i_id_use_rs2  = use2;
    assign bus_f.i_id_rd       = rd;
    assign bus_f.i_id_regwrite = rw;
    assign bus_f.i_id_memread  = mr;
    assign bus_f.i_id_halt     = halt;
    assign bus_f.i_ex_redirect = redir;

    assign bus_n.i_id_valid    = id_valid;
    assign bus_n.i_id_rs1      = rs1;
    assign bus_n.i_id_rs2      = rs2;
    assign bus_n.i_id_use_rs1  = use1;
    assign bus_n.i_id_use_rs2  = use2;
    assign bus_n.i_id_rd       = rd;
    assign bus_n.i_id_regwrite = rw;
    assign bus_n.i_id_memread  = mr;
    assign bus_n.i_id_halt     = halt;
    assign bus_n.i_ex_redirect = redir;

    pipe_hazard_ctrl #(.FWD_EN(1'b1)) u_fwd (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_f));
    pipe_hazard_ctrl #(.FWD_EN(1'b0)) u_nf  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int valid, input int r1, input int u1, input int r2,
                                input int u2, input int d, input int w, input int m,
                                input int h, input int rr, input int pc, input int fl,
                                input int bub, input int fa, input int fb, input int ret,
                                input int hlt);
        vec_t v;
        v.valid = 1'(valid); v.rs1 = 5'(r1); v.use1 = 1'(u1); v.rs2 = 5'(r2);
        v.use2 = 1'(u2); v.rd = 5'(d); v.rw = 1'(w); v.mr = 1'(m); v.halt = 1'(h);
        v.redir = 1'(rr); v.pc = 1'(pc); v.fl = 1'(fl); v.bub = 1'(bub);
        v.fa = 2'(fa); v.fb = 2'(fb); v.ret = 1'(ret); v.hlt = 1'(hlt);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_valid = v.valid; rs1 = v.rs1; use1 = v.use1; rs2 = v.rs2; use2 = v.use2;
        rd = v.rd; rw = v.rw; mr = v.mr; halt = v.halt; redir = v.redir;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Pop the oldest expectation and compare it with the selected instance
    task automatic check(input string tag, input bit nf);
        vec_t e;
        logic pc, ie, fl, bub, ret, hlt;
        logic [1:0] fa, fb;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        if (nf) begin
            pc = bus_n.o_pc_en; ie = bus_n.o_ifid_en; fl = bus_n.o_ifid_flush;
            bub = bus_n.o_idex_bubble; fa = bus_n.o_fwd_a; fb = bus_n.o_fwd_b;
            ret = bus_n.o_retire_halt; hlt = bus_n.o_halted;
        end else begin
            pc = bus_f.o_pc_en; ie = bus_f.o_ifid_en; fl = bus_f.o_ifid_flush;
            bub = bus_f.o_idex_bubble; fa = bus_f.o_fwd_a; fb = bus_f.o_fwd_b;
            ret = bus_f.o_retire_halt; hlt = bus_f.o_halted;
        end
        chk({tag, ".pc_en"},       8'(pc),  8'(e.pc));
        chk({tag, ".ifid_en"},     8'(ie),  8'(e.pc));
        chk({tag, ".ifid_flush"},  8'(fl),  8'(e.fl));
        chk({tag, ".idex_bubble"}, 8'(bub), 8'(e.bub));
        chk({tag, ".fwd_a"},       8'(fa),  8'(e.fa));
        chk({tag, ".fwd_b"},       8'(fb),  8'(e.fb));
        chk({tag, ".retire_halt"}, 8'(ret), 8'(e.ret));
        chk({tag, ".halted"},      8'(hlt), 8'(e.hlt));
    endtask

    task automatic step(input string tag, input vec_t v, input bit nf);
        @(negedge clk);
        drive(v);
        exp_q.push_back(v);
        #1;
        check(tag, nf);
    endtask

    // Assert reset asynchronously mid-cycle, check, then release with idle inputs
    task automatic rst_check(input string tag, input vec_t v, input bit nf);
        @(negedge clk);
        drive(v);
        #2 rst_n = 1'b0;
        exp_q.push_back(v);
        #1;
        check(tag, nf);
        @(negedge clk);
        drive(mk(0,0,0,0,0,0,0,0,0,0, 1,0,1, 0,0,0,0));
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        drive(mk(0,0,0,0,0,0,0,0,0,0, 1,0,1, 0,0,0,0));

        //            v rs1 u rs2 u rd rw mr h rr  pc fl bub fa fb ret hlt
        tbl[0]  = mk(1, 1,1, 0,0, 5,1,1,0,0,  1,0,0, 0,0,0,0); // lw x5
        tbl[1]  = mk(1, 5,1, 7,1, 6,1,0,0,0,  0,0,1, 0,0,0,0); // add x6,x5,x7 load-use
        tbl[2]  = mk(1, 5,1, 7,1, 6,1,0,0,0,  1,0,0, 0,0,0,0); // add advances
        tbl[3]  = mk(1, 0,1, 0,0, 5,1,0,0,0,  1,0,0, 2,0,0,0); // addi x5; add shows fwd_a=10
        tbl[4]  = mk(1, 5,1, 5,1, 6,1,0,0,0,  1,0,0, 0,0,0,0); // add x6,x5,x5
        tbl[5]  = mk(1, 1,1, 0,0, 0,1,0,0,0,  1,0,0, 1,1,0,0); // addi x0; fwd 01/01 shown
        tbl[6]  = mk(1, 0,1, 0,1, 6,1,0,0,0,  1,0,0, 0,0,0,0); // add x6,x0,x0
        tbl[7]  = mk(1, 0,1, 0,0, 5,1,0,0,0,  1,0,0, 0,0,0,0); // addi x5
        tbl[8]  = mk(1, 0,1, 0,0, 5,1,0,0,0,  1,0,0, 0,0,0,0); // addi x5 again
        tbl[9]  = mk(1, 5,1, 6,1, 6,1,0,0,0,  1,0,0, 0,0,0,0); // add x6,x5,x6
        tbl[10] = mk(1, 6,1, 5,1, 7,1,0,0,0,  1,0,0, 1,0,0,0); // add x7,x6,x5; youngest wins
        tbl[11] = mk(0, 0,0, 0,0, 0,0,0,0,0,  1,0,1, 1,2,0,0); // idle
        tbl[12] = mk(1, 0,0, 0,0, 8,1,1,0,0,  1,0,0, 0,0,0,0); // lw x8
        tbl[13] = mk(1, 8,1, 0,0, 9,1,0,0,1,  1,1,1, 0,0,0,0); // load-use plus redirect
        tbl[14] = mk(1, 0,1, 0,0, 9,1,0,0,1,  1,1,1, 0,0,0,0); // redirect, no hazard
        tbl[15] = mk(1, 8,1, 0,0,10,1,0,0,0,  1,0,0, 0,0,0,0); // load only in WB
        tbl[16] = mk(1, 0,0, 0,0, 0,0,0,1,0,  1,0,0, 0,0,0,0); // EBREAK advances (N)
        tbl[17] = mk(1, 0,0, 0,0, 3,1,0,0,1,  0,0,1, 0,0,0,0); // N+1 redirect ignored
        tbl[18] = mk(1, 0,0, 0,0, 3,1,0,0,0,  0,0,1, 0,0,0,0); // N+2
        tbl[19] = mk(1, 0,0, 0,0, 3,1,0,0,0,  0,0,1, 0,0,1,0); // N+3 retire pulse
        tbl[20] = mk(1, 0,0, 0,0, 3,1,0,0,1,  0,0,1, 0,0,0,1); // N+4 halted
        tbl[21] = mk(0, 0,0, 0,0, 0,0,0,0,0,  0,0,1, 0,0,0,1); // stays halted

        rst_check("reset0", mk(1,1,1,2,1,3,1,0,0,0, 1,0,0, 0,0,0,0), 1'b0);

        for (int i = 0; i < 22; i++)
            step($sformatf("tbl%0d", i), tbl[i], 1'b0);

        // Only reset leaves HALTED
        rst_check("reset_halted", mk(1,1,1,2,1,3,1,0,0,0, 1,0,0, 0,0,0,0), 1'b0);

        // EBREAK held by a load-use stall must not drain until it really issues
        step("b1", mk(1,0,0,0,0,5,1,1,0,0, 1,0,0, 0,0,0,0), 1'b0);
        step("b2", mk(1,5,1,0,0,0,0,0,1,0, 0,0,1, 0,0,0,0), 1'b0);
        step("b3", mk(1,5,1,0,0,0,0,0,1,0, 1,0,0, 0,0,0,0), 1'b0);
        step("b4", mk(0,0,0,0,0,0,0,0,0,0, 0,0,1, 2,0,0,0), 1'b0);
        step("b5", mk(0,0,0,0,0,0,0,0,0,0, 0,0,1, 0,0,0,0), 1'b0);
        rst_check("reset_drain", mk(1,1,1,2,1,3,1,0,0,0, 1,0,0, 0,0,0,0), 1'b0);
        for (int i = 0; i < 5; i++)
            step($sformatf("post_drain%0d", i), mk(0,0,0,0,0,0,0,0,0,0, 1,0,1, 0,0,0,0), 1'b0);

        // Stall-only instance: wait out EX, MEM and WB
        step("nf_addi", mk(1,0,1,0,0,5,1,0,0,0, 1,0,0, 0,0,0,0), 1'b1);
        for (int i = 0; i < 3; i++)
            step($sformatf("nf_stall%0d", i), mk(1,5,1,0,1,6,1,0,0,0, 0,0,1, 0,0,0,0), 1'b1);
        step("nf_adv",   mk(1,5,1,0,1,6,1,0,0,0, 1,0,0, 0,0,0,0), 1'b1);
        step("nf_addi0", mk(1,0,0,0,0,0,1,0,0,0, 1,0,0, 0,0,0,0), 1'b1);
        step("nf_use_x0", mk(1,0,1,0,0,6,1,0,0,0, 1,0,0, 0,0,0,0), 1'b1);
        step("nf_use_x6", mk(1,6,1,0,0,7,1,0,0,0, 0,0,1, 0,0,0,0), 1'b1);

        if (exp_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_drain leftover=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: FWD_EN, default 1, 1 = resolve EX/MEM RAW by forwarding; 0 = stall until producer leaves WB.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_id_valid  input  1  decode stage holds a valid instruction.
REQ-005 i_id_rs1, i_id_rs2  input  5 each  decode source register indices.
REQ-006 i_id_use_rs1, i_id_use_rs2  input  1 each  decode instruction reads that source.
REQ-007 i_id_rd  input  5  decode destination index.
REQ-008 i_id_regwrite, i_id_memread, i_id_halt  input  1 each  decode RegWrite, load, EBREAK flags.
REQ-009 i_ex_redirect  input  1  EX-stage branch/jump taken this cycle.
REQ-010 o_pc_en, o_ifid_en  output  1 each  PC and IF/ID register write enables.
REQ-011 o_ifid_flush  output  1  IF/ID register cleared to bubble at next edge.
REQ-012 o_idex_bubble  output  1  ID/EX register loads a bubble instead of ID contents.
REQ-013 o_fwd_a, o_fwd_b  output  2 each  registered EX operand select: 00 regfile, 01 MEM result, 10 WB result.
REQ-014 o_retire_halt  output  1  one-cycle pulse when EBREAK occupies WB.
REQ-015 o_halted  output  1  level, core halted.

Function
REQ-016 Block SHALL keep shadow slots EX, MEM, WB, each {valid, rd, regwrite, memread, halt}; each edge WB<=MEM, MEM<=EX, EX<=ID fields if ID advances else invalid.
REQ-017 ID advances iff i_id_valid & state RUN & !stall & !i_ex_redirect.
REQ-018 A slot SHALL count as producer for rs only if valid & regwrite & rd==rs & rd!=0; x0 never hazards or forwards.
REQ-019 FWD_EN=1: stall SHALL assert iff EX producer is memread and matches a used rs (load-use, exactly one bubble).
REQ-020 FWD_EN=0: stall SHALL assert iff any used rs matches a producer in EX, MEM or WB.
REQ-021 o_fwd_a/b SHALL register at the edge ID advances: 01 if EX slot produces rs, else 10 if MEM slot produces rs, else 00; EX-slot match has priority; FWD_EN=0 forces 00; non-advancing edge loads 00.
REQ-022 Combinational: o_pc_en = o_ifid_en = RUN & !stall (redirect still enables PC); o_ifid_flush = RUN & i_ex_redirect; o_idex_bubble = !ID advances.
REQ-023 i_ex_redirect SHALL override stall in the same cycle.
REQ-024 FSM states RUN, DRAIN, HALTED; RUN->DRAIN when ID advances with i_id_halt=1.
REQ-025 In DRAIN: o_pc_en=o_ifid_en=0, o_ifid_flush=0, bubbles only, i_ex_redirect ignored (older instructions all ahead of EBREAK).
REQ-026 DRAIN->HALTED on the edge after the WB slot holds halt; o_retire_halt=1 exactly while WB slot holds valid halt (combinational from slot).
REQ-027 HALTED: all enables 0, o_idex_bubble=1, o_halted=1, exits only by reset.
REQ-028 i_id_halt with stall or redirect SHALL NOT enter DRAIN that cycle.

Reset
REQ-029 On i_rst_n low, immediately and asynchronously: all slots invalid, state RUN, o_fwd_a=o_fwd_b=00, o_retire_halt=0, o_halted=0; combinational enables then read 1 if i_id_valid hazards absent.
REQ-030 Reset asserted mid-DRAIN SHALL abandon halt; release resumes RUN with empty slots.

Verification
REQ-031 lw x5 then add x6,x5,x7 (use_rs1): one cycle o_pc_en=0, o_idex_bubble=1; next cycle add advances, o_fwd_a=10.
REQ-032 addi x5 then add x6,x5,x5: no stall, o_fwd_a=o_fwd_b=01; with x0 as rd instead: o_fwd 00.
REQ-033 addi x5 in MEM and addi x5 in EX, consumer reads x5: o_fwd_a=01 (youngest wins).
REQ-034 i_ex_redirect=1 same cycle as load-use stall: o_ifid_flush=1, o_idex_bubble=1, o_pc_en=1.
REQ-035 EBREAK advances at cycle N: o_retire_halt pulses at cycle N+3, o_halted=1 from N+4, o_pc_en=0 from N+1.
REQ-036 FWD_EN=0, addi x5 then add x6,x5,x0: three stall cycles, then advance with o_fwd_a=00.
